// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: operation codes, result
// classes, bus widths, multiplier FSM state codes and a shift helper.
package ex_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;

    localparam logic [DATA_W-1:0] ZeroWord = 32'h0000_0000;

    // aluop codes
    localparam logic [ALUOP_W-1:0] OR_OP    = 8'h25;
    localparam logic [ALUOP_W-1:0] AND_OP   = 8'h24;
    localparam logic [ALUOP_W-1:0] XOR_OP   = 8'h26;
    localparam logic [ALUOP_W-1:0] NOR_OP   = 8'h27;
    localparam logic [ALUOP_W-1:0] SLL_OP   = 8'h7C;
    localparam logic [ALUOP_W-1:0] SRL_OP   = 8'h02;
    localparam logic [ALUOP_W-1:0] SRA_OP   = 8'h03;
    localparam logic [ALUOP_W-1:0] MFHI_OP  = 8'h10;
    localparam logic [ALUOP_W-1:0] MFLO_OP  = 8'h12;
    localparam logic [ALUOP_W-1:0] MULTU_OP = 8'h19;

    // alusel result classes
    localparam logic [ALUSEL_W-1:0] RES_NOP   = 3'd0;
    localparam logic [ALUSEL_W-1:0] RES_LOGIC = 3'd1;
    localparam logic [ALUSEL_W-1:0] RES_SHIFT = 3'd2;
    localparam logic [ALUSEL_W-1:0] RES_MOVE  = 3'd3;
    localparam logic [ALUSEL_W-1:0] RES_ARITH = 3'd4;

    // Iterative multiplier FSM states
    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    // Shift unit: shifts val by sh; unknown ops give zero.
    function automatic logic [DATA_W-1:0] shift_result(
        input logic [ALUOP_W-1:0] op,
        input logic [4:0]         sh,
        input logic [DATA_W-1:0]  val
    );
        logic [DATA_W-1:0] r;
        r = ZeroWord;
        case (op)
            SLL_OP:  r = val << sh;
            SRL_OP:  r = val >> sh;
            SRA_OP:  r = $signed(val) >>> sh;
            default: r = ZeroWord;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative unsigned 32x32 shift-add multiplier, one multiplier bit per
// cycle. IDLE -> BUSY on start (operands latched), 32 BUSY cycles, then one
// DONE cycle. 'product' is the complete result during the last BUSY cycle
// (last=1), so the owner can capture it on that same edge.
// Handshake: start is sampled only in IDLE; busy is high in BUSY; done is
// high for exactly one cycle after the final step. 'state' is a debug view.
module mul_iter
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              last,
    output logic [63:0]       product,
    output logic [1:0]        state
);

    logic [1:0]        state_q;
    logic [4:0]        cnt;
    logic [63:0]       mcand;
    logic [DATA_W-1:0] mplier;
    logic [63:0]       acc;
    logic [63:0]       acc_next;

    // Partial sum after processing the current multiplier bit.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : 64'd0);
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign last    = busy && (cnt == 5'd31);
    assign product = acc_next;
    assign state   = state_q;

    // FSM and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt     <= 5'd0;
            mcand   <= 64'd0;
            mplier  <= '0;
            acc     <= 64'd0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        state_q <= MUL_BUSY;
                        cnt     <= 5'd0;
                        mcand   <= {32'd0, a};
                        mplier  <= b;
                        acc     <= 64'd0;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: state_q <= MUL_IDLE;
                default:  state_q <= MUL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex.sv
// Execute stage: logic, shift and HI/LO move operations with a one-cycle
// registered result. Macro EX_MULT_EN adds the iterative MULTU unit, the
// HI/LO registers, MFHI/MFLO and the stall request; without it those ops
// behave as unknown (result 0, destination passed through).
module ex
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [ALUSEL_W-1:0]   alusel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stallreq_o
);

    logic [DATA_W-1:0] result;
    logic              wreg_eff;

`ifdef EX_MULT_EN
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              is_multu;
    logic              mul_busy;
    logic              mul_done;
    logic              mul_last;
    logic [63:0]       mul_product;
    logic [1:0]        mul_state;

    assign is_multu = (aluop_i == MULTU_OP);

    mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (is_multu),
        .a       (reg1_i),
        .b       (reg2_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .last    (mul_last),
        .product (mul_product),
        .state   (mul_state)
    );

    // Hold upstream while a MULTU is at the input and not yet finished.
    assign stallreq_o = !rst && is_multu && (mul_state != MUL_DONE);

    // HI/LO capture the full product on the final multiply step.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= ZeroWord;
            lo <= ZeroWord;
        end else if (mul_busy && mul_last) begin
            hi <= mul_product[63:32];
            lo <= mul_product[31:0];
        end
    end

    // A retiring MULTU never writes a GPR.
    always_comb begin
        wreg_eff = wreg_i && !(is_multu && mul_done);
    end
`else
    assign stallreq_o = 1'b0;

    // Without the multiplier every op passes its write enable through.
    always_comb begin
        wreg_eff = wreg_i;
    end
`endif

    // Result selection by class, then by subtype; anything unknown is zero.
    always_comb begin
        result = ZeroWord;
        case (alusel_i)
            RES_LOGIC: begin
                case (aluop_i)
                    OR_OP:   result = reg1_i | reg2_i;
                    AND_OP:  result = reg1_i & reg2_i;
                    XOR_OP:  result = reg1_i ^ reg2_i;
                    NOR_OP:  result = ~(reg1_i | reg2_i);
                    default: result = ZeroWord;
                endcase
            end
            RES_SHIFT: result = shift_result(aluop_i, reg1_i[4:0], reg2_i);
`ifdef EX_MULT_EN
            RES_MOVE: begin
                case (aluop_i)
                    MFHI_OP: result = hi;
                    MFLO_OP: result = lo;
                    default: result = ZeroWord;
                endcase
            end
`endif
            default: result = ZeroWord;
        endcase
    end

    // Output register to MEM; a stall loads a bubble.
    always_ff @(posedge clk) begin
        if (rst || stallreq_o) begin
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= ZeroWord;
        end else begin
            wd_o    <= wd_i;
            wreg_o  <= wreg_eff;
            wdata_o <= result;
        end
    end

endmodule

// File: tb/tb_ex.sv
// Testbench for ex: directed cases plus randomized ops, checked against a
// behavioural model through an expected-output queue.
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = 8'h00;
    logic [2:0]  alusel_i = 3'd0;
    logic [31:0] reg1_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    ex dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o)
    );

    // clock
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // expected {wreg, wd, wdata}
    logic [37:0] exp_q[$];

    // reference model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_age = 0;      // 0 idle, 1..32 multiplying, 33 finished
    logic [63:0] m_pend = 64'd0;
    bit          last_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [2:0] sel,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh  = int'(a[4:0]);
        ext = {{32{b[31]}}, b};
        if (sel == 3'd1) begin
            if (op == 8'h25) return a | b;
            if (op == 8'h24) return a & b;
            if (op == 8'h26) return a ^ b;
            if (op == 8'h27) return ~(a | b);
            return 32'd0;
        end
        if (sel == 3'd2) begin
            if (op == 8'h7C) return b << sh;
            if (op == 8'h02) return b >> sh;
            if (op == 8'h03) return 32'(ext >> sh);
            return 32'd0;
        end
`ifdef EX_MULT_EN
        if (sel == 3'd3) begin
            if (op == 8'h10) return m_hi;
            if (op == 8'h12) return m_lo;
        end
`endif
        return 32'd0;
    endfunction

    // driver: present one cycle of inputs, check the stall request, push the
    // expected registered output and advance the model by one edge
    task automatic cycle(input logic r, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic w);
        bit          stall;
        bit          multu;
        logic        wexp;
        logic [37:0] e;
        @(negedge clk);
        rst = r; aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = d; wreg_i = w;
        #1;
        multu = (op == 8'h19);
        if (r) begin
            stall = 1'b0;
            e     = 38'd0;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            m_age = 0;
        end else begin
`ifdef EX_MULT_EN
            stall = multu && (m_age != 33);
            wexp  = w && !multu;
`else
            stall = 1'b0;
            wexp  = w;
`endif
            e = stall ? 38'd0 : {wexp, d, ref_result(op, sel, a, b)};
`ifdef EX_MULT_EN
            if (m_age == 0) begin
                if (multu) begin
                    m_age  = 1;
                    m_pend = {32'd0, a} * {32'd0, b};
                end
            end else if (m_age == 33) begin
                m_age = 0;
            end else begin
                m_age++;
                if (m_age == 33) begin
                    m_hi = m_pend[63:32];
                    m_lo = m_pend[31:0];
                end
            end
`endif
        end
        check("stallreq", {63'd0, stallreq_o}, {63'd0, stall});
        last_stall = stall;
        exp_q.push_back(e);
    endtask

    // hold MULTU until the stall drops (bounded); optionally scramble operands
    task automatic do_multu(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                            output int stalls);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            if (scramble && i > 0)
                cycle(1'b0, 8'h19, 3'd0, $urandom, $urandom, 5'd9, 1'b1);
            else
                cycle(1'b0, 8'h19, 3'd0, a, b, 5'd9, 1'b1);
            if (last_stall) stalls++;
            else break;
        end
    endtask

    // monitor: compare every registered output against the scoreboard
    always @(posedge clk) begin
        logic [37:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out{wreg,wd,wdata}", {26'd0, wreg_o, wd_o, wdata_o}, {26'd0, e});
        end
    end

    logic [7:0] op_tab[10] = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h10, 8'h12, 8'h5A};
    logic [2:0] sel_tab[10] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};

    initial begin
        int st;
        int k;
        int exp_stalls;
`ifdef EX_MULT_EN
        exp_stalls = 33;
`else
        exp_stalls = 0;
`endif
        // reset
        cycle(1'b1, 8'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        cycle(1'b1, 8'h25, 3'd1, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1);

        // Test 1: OR
        cycle(1'b0, OR_OP, RES_LOGIC, 32'h0000_1100, 32'h0000_0101, 5'd3, 1'b1);
        // Test 2: SRA / SRL
        cycle(1'b0, SRA_OP, RES_SHIFT, 32'd4, 32'h8000_0000, 5'd4, 1'b1);
        cycle(1'b0, SRL_OP, RES_SHIFT, 32'd4, 32'h8000_0000, 5'd4, 1'b1);
        cycle(1'b0, SLL_OP, RES_SHIFT, 32'd31, 32'h0000_0003, 5'd5, 1'b1);
        cycle(1'b0, NOR_OP, RES_NOP, 32'h1234, 32'h5678, 5'd6, 1'b1);

        // Test 3: MULTU held, then MFHI/MFLO
        do_multu(32'hFFFF_FFFF, 32'd2, 1'b0, st);
        check("multu_stall_cycles", 64'(st), 64'(exp_stalls));
        cycle(1'b0, MFHI_OP, RES_MOVE, 32'd0, 32'd0, 5'd10, 1'b1);
        cycle(1'b0, MFLO_OP, RES_MOVE, 32'd0, 32'd0, 5'd11, 1'b1);

        // Test 4: operands change while multiplying
        do_multu(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, st);
        cycle(1'b0, MFHI_OP, RES_MOVE, 32'd0, 32'd0, 5'd12, 1'b1);
        cycle(1'b0, MFLO_OP, RES_MOVE, 32'd0, 32'd0, 5'd13, 1'b1);

        // Test 5: reset at cnt=10, then a fresh multiply
        for (int i = 0; i < 11; i++)
            cycle(1'b0, MULTU_OP, RES_NOP, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd14, 1'b1);
        cycle(1'b1, MULTU_OP, RES_NOP, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd14, 1'b1);
        cycle(1'b0, MFHI_OP, RES_MOVE, 32'd0, 32'd0, 5'd15, 1'b1);
        cycle(1'b0, MFLO_OP, RES_MOVE, 32'd0, 32'd0, 5'd16, 1'b1);
        do_multu(32'h0001_0003, 32'h0002_0005, 1'b0, st);
        check("multu_after_reset_stalls", 64'(st), 64'(exp_stalls));
        cycle(1'b0, MFHI_OP, RES_MOVE, 32'd0, 32'd0, 5'd17, 1'b1);
        cycle(1'b0, MFLO_OP, RES_MOVE, 32'd0, 32'd0, 5'd18, 1'b1);

        // random traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 14) == 0) begin
                do_multu($urandom, $urandom, bit'($urandom_range(0, 1)), st);
            end else begin
                k = $urandom_range(0, 9);
                cycle(1'b0, op_tab[k],
                      ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : sel_tab[k],
                      $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
        end

        // drain
        cycle(1'b0, 8'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
